tl_vc_arbiter: RTL

- Transaction-layer scheduler for NUM_VC per-virtual-channel 12-bit FIFOs feeding one shared downstream FIFO.
- Runs the main link-side state machine and drives the FIFO `state[3:0]` and `init_full` / `init_empty` threshold configuration.
- Pops the source FIFOs round-robin and pushes each popped word into the downstream FIFO, honouring its almost_full backpressure.

---
 rtl/tl_vc_arbiter.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/tl_vc_arbiter.sv
// tl_vc_arbiter: link-side FSM plus NUM_VC-way pop scheduler that moves words
// from the per-VC source FIFOs into one downstream FIFO with a fixed two-cycle
// pop-to-push latency.
// Build option: ARB_STRICT_PRIO_EN selects fixed priority (VC0 highest)
// instead of round-robin.
module tl_vc_arbiter #(
    parameter int NUM_VC       = 4,
    parameter int LINE_SIZE    = 12,
    parameter int ADDRESS_SIZE = 3,
    parameter int DEF_FULL     = 6,
    parameter int DEF_EMPTY    = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        init,
    input  logic [ADDRESS_SIZE-1:0]     init_full_in,
    input  logic [ADDRESS_SIZE-1:0]     init_empty_in,
    input  logic [NUM_VC-1:0]           vc_empty,
    input  logic [NUM_VC*LINE_SIZE-1:0] vc_data,
    input  logic                        out_almost_full,
    output logic [NUM_VC-1:0]           vc_pop,
    output logic                        out_push,
    output logic [LINE_SIZE-1:0]        out_data,
    output logic [3:0]                  state,
    output logic [ADDRESS_SIZE-1:0]     init_full,
    output logic [ADDRESS_SIZE-1:0]     init_empty,
    output logic                        idle
);

    localparam int PW = $clog2(NUM_VC);

    typedef enum logic [3:0] {
        S_RESET  = 4'b0001,
        S_INIT   = 4'b0010,
        S_IDLE   = 4'b0100,
        S_ACTIVE = 4'b1000
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDRESS_SIZE-1:0] init_full_q, init_empty_q;
    logic                    p1_valid_q;
    logic [PW-1:0]           p1_sel_q;
    logic                    out_push_q;
    logic [LINE_SIZE-1:0]    out_data_q;
    logic                    grant_valid;
    logic [PW-1:0]           grant_idx;
    logic [PW-1:0]           search_idx;
    logic [PW-1:0]           start_idx;
    logic [LINE_SIZE-1:0]    sel_word;

`ifdef ARB_STRICT_PRIO_EN
    // Fixed priority: the search always begins at VC0.
    always_comb begin
        start_idx = '0;
    end
`else
    logic [PW-1:0] rr_q;

    // Round-robin pointer: moves to the VC after the one just granted.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_q <= '0;
        end else if (grant_valid) begin
            rr_q <= grant_idx + PW'(1);
        end
    end

    // Round-robin: the search begins at the pointer.
    always_comb begin
        start_idx = rr_q;
    end
`endif

    // Grant search: first non-empty VC from start_idx upward, wrapping modulo NUM_VC.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        search_idx  = '0;
        vc_pop      = '0;
        if (state_q == S_ACTIVE && !init && !out_almost_full) begin
            for (int unsigned i = 0; i < NUM_VC; i++) begin
                search_idx = start_idx + PW'(i);
                if (!grant_valid && !vc_empty[search_idx]) begin
                    grant_valid = 1'b1;
                    grant_idx   = search_idx;
                end
            end
        end
        if (grant_valid) begin
            vc_pop[grant_idx] = 1'b1;
        end
    end

    // Next-state logic; init takes priority over traffic in IDLE and ACTIVE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RESET:  state_d = S_INIT;
            S_INIT:   if (!init) state_d = S_IDLE;
            S_IDLE: begin
                if (init)                 state_d = S_INIT;
                else if (vc_empty != '1)  state_d = S_ACTIVE;
            end
            S_ACTIVE: begin
                if (init)                                 state_d = S_INIT;
                else if (vc_empty == '1 && !p1_valid_q)   state_d = S_IDLE;
            end
            default:  state_d = S_RESET;
        endcase
    end

    // State register and threshold configuration, loaded while in INIT.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_RESET;
            init_full_q  <= ADDRESS_SIZE'(DEF_FULL);
            init_empty_q <= ADDRESS_SIZE'(DEF_EMPTY);
        end else begin
            state_q <= state_d;
            if (state_q == S_INIT) begin
                init_full_q  <= init_full_in;
                init_empty_q <= init_empty_in;
            end
        end
    end

    // Select the word the previously popped source FIFO is now presenting.
    always_comb begin
        sel_word = '0;
        for (int unsigned i = 0; i < NUM_VC; i++) begin
            if (PW'(i) == p1_sel_q) begin
                sel_word = vc_data[i*LINE_SIZE +: LINE_SIZE];
            end
        end
    end

    // Two-stage pop-to-push pipeline; it drains independently of the FSM state.
    always_ff @(posedge clk) begin
        if (reset) begin
            p1_valid_q <= 1'b0;
            p1_sel_q   <= '0;
            out_push_q <= 1'b0;
            out_data_q <= '0;
        end else begin
            p1_valid_q <= grant_valid;
            p1_sel_q   <= grant_idx;
            out_push_q <= p1_valid_q;
            if (p1_valid_q) begin
                out_data_q <= sel_word;
            end
        end
    end

    // Output mapping.
    always_comb begin
        state      = state_q;
        idle       = (state_q == S_IDLE);
        init_full  = init_full_q;
        init_empty = init_empty_q;
        out_push   = out_push_q;
        out_data   = out_data_q;
    end

endmodule
